// File: rtl/if_id_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : if_id_stage
//  Purpose  : IF/ID pipeline boundary. A 2-entry skid buffer holds {instr, pc}
//             with valid/ready on both sides, a redirect flush and a
//             saturating decode-stall counter.
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_stage #(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR   = 32'h0000_0000,
    parameter int                STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      instr_in,
    input  logic [DATA_W-1:0]      pc_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output logic [DATA_W-1:0]      instr_out,
    output logic [DATA_W-1:0]      pc_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // Occupancy encoding: slot0 is always the head, slot1 only used when full.
    localparam logic [1:0] c_cnt_empty = 2'd0;
    localparam logic [1:0] c_cnt_one   = 2'd1;
    localparam logic [1:0] c_cnt_full  = 2'd2;

    localparam logic [DATA_W-1:0]      c_pc_zero = '0;
    localparam logic [STALL_CNT_W-1:0] c_stall_one = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]             r_count;
    logic [DATA_W-1:0]      r_slot0_instr;
    logic [DATA_W-1:0]      r_slot0_pc;
    logic [DATA_W-1:0]      r_slot1_instr;
    logic [DATA_W-1:0]      r_slot1_pc;
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    logic [1:0]             w_count_nxt;
    logic [DATA_W-1:0]      w_slot0_instr_nxt;
    logic [DATA_W-1:0]      w_slot0_pc_nxt;
    logic [DATA_W-1:0]      w_slot1_instr_nxt;
    logic [DATA_W-1:0]      w_slot1_pc_nxt;

    logic                   w_in_ready;
    logic                   w_out_valid;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_stall;
    logic                   w_stall_sat;

    // Handshake qualifiers come from registered occupancy only, so in_ready
    // never has a combinational path from out_ready.
    assign w_in_ready  = (r_count != c_cnt_full);
    assign w_out_valid = (r_count != c_cnt_empty);
    assign w_push      = in_valid & w_in_ready & ~flush;
    assign w_pop       = w_out_valid & out_ready;
    assign w_stall     = w_out_valid & ~out_ready & ~flush;
    assign w_stall_sat = &r_stall_cycles;

    always_comb begin
        w_count_nxt       = r_count;
        w_slot0_instr_nxt = r_slot0_instr;
        w_slot0_pc_nxt    = r_slot0_pc;
        w_slot1_instr_nxt = r_slot1_instr;
        w_slot1_pc_nxt    = r_slot1_pc;

        if (flush) begin
            w_count_nxt       = c_cnt_empty;
            w_slot0_instr_nxt = NOP_INSTR;
            w_slot0_pc_nxt    = c_pc_zero;
            w_slot1_instr_nxt = NOP_INSTR;
            w_slot1_pc_nxt    = c_pc_zero;
        end else begin
            case (r_count)
                c_cnt_empty: begin
                    if (w_push) begin
                        w_slot0_instr_nxt = instr_in;
                        w_slot0_pc_nxt    = pc_in;
                        w_count_nxt       = c_cnt_one;
                    end
                end
                c_cnt_one: begin
                    if (w_push && w_pop) begin
                        w_slot0_instr_nxt = instr_in;
                        w_slot0_pc_nxt    = pc_in;
                    end else if (w_push) begin
                        w_slot1_instr_nxt = instr_in;
                        w_slot1_pc_nxt    = pc_in;
                        w_count_nxt       = c_cnt_full;
                    end else if (w_pop) begin
                        w_slot0_instr_nxt = NOP_INSTR;
                        w_slot0_pc_nxt    = c_pc_zero;
                        w_count_nxt       = c_cnt_empty;
                    end
                end
                c_cnt_full: begin
                    if (w_pop) begin
                        w_slot0_instr_nxt = r_slot1_instr;
                        w_slot0_pc_nxt    = r_slot1_pc;
                        w_slot1_instr_nxt = NOP_INSTR;
                        w_slot1_pc_nxt    = c_pc_zero;
                        w_count_nxt       = c_cnt_one;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty buffer.
                    w_count_nxt       = c_cnt_empty;
                    w_slot0_instr_nxt = NOP_INSTR;
                    w_slot0_pc_nxt    = c_pc_zero;
                    w_slot1_instr_nxt = NOP_INSTR;
                    w_slot1_pc_nxt    = c_pc_zero;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= c_cnt_empty;
            r_slot0_instr <= NOP_INSTR;
            r_slot0_pc    <= c_pc_zero;
            r_slot1_instr <= NOP_INSTR;
            r_slot1_pc    <= c_pc_zero;
        end else begin
            r_count       <= w_count_nxt;
            r_slot0_instr <= w_slot0_instr_nxt;
            r_slot0_pc    <= w_slot0_pc_nxt;
            r_slot1_instr <= w_slot1_instr_nxt;
            r_slot1_pc    <= w_slot1_pc_nxt;
        end
    end

    // Stall counter survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && !w_stall_sat) begin
            r_stall_cycles <= r_stall_cycles + c_stall_one;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign instr_out    = w_out_valid ? r_slot0_instr : NOP_INSTR;
    assign pc_out       = w_out_valid ? r_slot0_pc    : c_pc_zero;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_stage
//  Purpose  : Scoreboard bench for if_id_stage: directed scenarios followed by
//             randomized traffic against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

    localparam int          DATA_W = 32;
    localparam logic [31:0] c_nop  = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_in = '0;
    logic [31:0] pc_in = '0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] instr_out, pc_out;
    logic [15:0] stall_cycles;

    logic        in_ready4, out_valid4;
    logic [31:0] instr_out4, pc_out4;
    logic [3:0]  stall_cycles4;

    ent_t exp_q[$];
    int   exp_stall  = 0;
    int   exp_stall4 = 0;
    int   n_checks   = 0;
    int   n_fail     = 0;

    always #5 clk = ~clk;

    if_id_stage #(.DATA_W(DATA_W), .NOP_INSTR(c_nop), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .instr_out(instr_out), .pc_out(pc_out), .out_valid(out_valid),
        .out_ready(out_ready), .stall_cycles(stall_cycles)
    );

    if_id_stage #(.DATA_W(DATA_W), .NOP_INSTR(c_nop), .STALL_CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
        .in_valid(in_valid), .in_ready(in_ready4), .flush(flush),
        .instr_out(instr_out4), .pc_out(pc_out4), .out_valid(out_valid4),
        .out_ready(out_ready), .stall_cycles(stall_cycles4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: samples 2 ns before the rising edge, compares against the model
    // and retires the head whenever decode takes it.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            begin
                logic        ev;
                logic [31:0] e_instr, e_pc;
                ev      = (exp_q.size() != 0);
                e_instr = ev ? exp_q[0].instr : c_nop;
                e_pc    = ev ? exp_q[0].pc    : 32'h0;
                chk("out_valid",    {31'b0, out_valid},  {31'b0, ev});
                chk("instr_out",    instr_out,           e_instr);
                chk("pc_out",       pc_out,              e_pc);
                chk("in_ready",     {31'b0, in_ready},   {31'b0, exp_q.size() != 2});
                chk("stall_cycles", {16'b0, stall_cycles}, exp_stall);
                chk("out_valid_w4", {31'b0, out_valid4}, {31'b0, ev});
                chk("instr_out_w4", instr_out4,          e_instr);
                chk("pc_out_w4",    pc_out4,             e_pc);
                chk("in_ready_w4",  {31'b0, in_ready4},  {31'b0, exp_q.size() != 2});
                chk("stall_sat_w4", {28'b0, stall_cycles4}, exp_stall4);

                if (rst) begin
                    exp_stall  = 0;
                    exp_stall4 = 0;
                end else if (ev && !out_ready && !flush) begin
                    if (exp_stall  < 65535) exp_stall++;
                    if (exp_stall4 < 15)    exp_stall4++;
                end
                if (ev && out_ready && !flush && !rst) void'(exp_q.pop_front());
            end
        end
    end

    // Drives one cycle of inputs; the accepted word (if any) becomes an
    // expected output. Acceptance is judged on the model's occupancy.
    task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rs, output logic acc);
        @(negedge clk);
        in_valid  = iv;
        instr_in  = ins;
        pc_in     = pc;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        acc       = iv && !fl && !rs && (exp_q.size() < 2);
        #4;
        if (rs || fl) exp_q.delete();
        else if (acc) exp_q.push_back('{ins, pc});
    endtask

    initial begin
        logic        acc;
        logic [31:0] w_i, w_p;
        int          thr;

        // Reset
        cyc(0, 32'h0, 32'h0, 0, 0, 1, acc);
        cyc(0, 32'h0, 32'h0, 0, 0, 1, acc);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, acc);

        // Streaming
        cyc(1, 32'hA, 32'd0, 1, 0, 0, acc);
        cyc(1, 32'hB, 32'd4, 1, 0, 0, acc);
        cyc(1, 32'hC, 32'd8, 1, 0, 0, acc);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, acc);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, acc);

        // Back-pressure, then fetch re-presents C until taken
        cyc(1, 32'hA, 32'd0, 0, 0, 0, acc);
        cyc(1, 32'hB, 32'd4, 0, 0, 0, acc);
        for (int i = 0; i < 3; i++) cyc(1, 32'hC, 32'd8, 0, 0, 0, acc);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'hC, 32'd8, 1, 0, 0, acc);
            if (acc) break;
        end
        for (int i = 0; i < 4; i++) cyc(0, 32'h0, 32'h0, 1, 0, 0, acc);

        // Flush while full, D discarded
        cyc(1, 32'hA, 32'd0, 0, 0, 0, acc);
        cyc(1, 32'hB, 32'd4, 0, 0, 0, acc);
        cyc(1, 32'hD, 32'd12, 0, 1, 0, acc);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, acc);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, acc);

        // Push and pop together at count 1
        cyc(1, 32'hA, 32'd0, 0, 0, 0, acc);
        cyc(1, 32'hB, 32'd4, 1, 0, 0, acc);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, acc);

        // Stall counter saturation on the 4-bit instance
        cyc(1, 32'hA, 32'd0, 0, 0, 0, acc);
        for (int i = 0; i < 20; i++) cyc(0, 32'h0, 32'h0, 0, 0, 0, acc);
        cyc(0, 32'h0, 32'h0, 0, 1, 0, acc);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, acc);

        // Reset mid-stream together with flush and a valid input
        cyc(1, 32'hA, 32'd0, 0, 0, 0, acc);
        cyc(1, 32'hB, 32'd4, 0, 0, 0, acc);
        cyc(1, 32'hE, 32'd16, 0, 1, 1, acc);
        cyc(0, 32'h0, 32'h0, 0, 0, 0, acc);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, acc);

        // Randomized traffic with phased back-pressure
        w_i = $urandom;
        w_p = 32'h100;
        thr = 50;
        for (int k = 0; k < 3000; k++) begin
            if (k % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0:       thr = 10;
                    1:       thr = 50;
                    default: thr = 95;
                endcase
            end
            cyc($urandom_range(0, 3) != 0, w_i, w_p,
                $urandom_range(0, 99) < thr,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 299) == 0, acc);
            if (acc) begin
                w_i = $urandom;
                w_p = w_p + 32'd4;
            end else if (flush || rst) begin
                w_i = $urandom;
                w_p = $urandom & 32'hFFFF_FFFC;
            end
        end

        cyc(0, 32'h0, 32'h0, 1, 0, 0, acc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
